// File: rtl/pht_update_unit.sv
// pht_update_unit
//   Writer-side companion to the 2-bit pattern history table. Resolved branch
//   outcomes are queued in a small FIFO; each entry is looked up through the
//   PHT state port, the saturating update is computed, and the PHT write port
//   (load/in/write_index) is driven for one cycle. The PHT commits on the
//   falling edge of that cycle.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   resolve_valid/index/taken/ready   resolved-branch push interface
//   pht_write_index     index presented to the PHT write/state port (registered)
//   pht_current_state   PHT counter at pht_write_index (combinational from PHT)
//   pht_load, pht_in    PHT write enable and new counter value (registered)
//   occupancy           number of queued entries
//
// state  | meaning
// IDLE   | FIFO empty, write index parked at 0
// LOOKUP | head index presented, PHT counter being read
// COMMIT | pht_load/pht_in driven; head pops at the end of the cycle
module pht_update_unit #(
  parameter int entry = 8,
  parameter int depth = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       resolve_valid,
  input  logic [entry-1:0]           resolve_index,
  input  logic                       resolve_taken,
  output logic                       resolve_ready,
  output logic [entry-1:0]           pht_write_index,
  input  logic [1:0]                 pht_current_state,
  output logic                       pht_load,
  output logic [1:0]                 pht_in,
  output logic [$clog2(depth):0]     occupancy
);

  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(depth);

  typedef enum logic [1:0] {IDLE, LOOKUP, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [entry-1:0] fifo_idx   [depth];
  logic             fifo_taken [depth];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [entry-1:0] widx_q, widx_d;
  logic             load_q, load_d;
  logic [1:0]       in_q, in_d;
  logic             push, pop;
  logic [1:0]       sat_val;

  // Ready comes from the registered count only, so a full FIFO refuses a push
  // even in a cycle that pops.
  assign resolve_ready   = (count_q != FULL_C);
  assign push            = resolve_valid && resolve_ready;
  assign pop             = (state_q == COMMIT);
  assign occupancy       = count_q;
  assign pht_write_index = widx_q;
  assign pht_load        = load_q;
  assign pht_in          = in_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr_q]   <= resolve_index;
      fifo_taken[wr_ptr_q] <= resolve_taken;
    end
  end

  always_comb begin
    sat_val = pht_current_state;
    if (fifo_taken[rd_ptr_q]) begin
      if (pht_current_state != 2'b11) sat_val = pht_current_state + 2'b01;
    end else begin
      if (pht_current_state != 2'b00) sat_val = pht_current_state - 2'b01;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    load_d  = load_q;
    in_d    = in_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = LOOKUP;
          widx_d  = fifo_idx[rd_ptr_q];
        end
      end
      LOOKUP: begin
        state_d = COMMIT;
        in_d    = sat_val;
        load_d  = (sat_val != pht_current_state);
      end
      COMMIT: begin
        load_d = 1'b0;
        if (count_d != '0) begin
          state_d = LOOKUP;
          // With one entry left, the next head is the one being pushed right
          // now and is not in the storage array yet.
          widx_d  = (count_q == CW'(1)) ? resolve_index : fifo_idx[rd_ptr_d];
        end else begin
          state_d = IDLE;
          widx_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        widx_d  = '0;
        load_d  = 1'b0;
      end
    endcase
  end

  // Async clear of load_q abandons an in-flight COMMIT before its falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      widx_q   <= '0;
      load_q   <= 1'b0;
      in_q     <= 2'b00;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      widx_q   <= widx_d;
      load_q   <= load_d;
      in_q     <= in_d;
    end
  end

endmodule

// File: tb/tb_pht_update_unit.sv
module tb_pht_update_unit;

  logic       clk;
  logic       rst_n;
  logic       resolve_valid;
  logic [7:0] resolve_index;
  logic       resolve_taken;
  logic       resolve_ready;
  logic [7:0] pht_write_index;
  logic [1:0] pht_current_state;
  logic       pht_load;
  logic [1:0] pht_in;
  logic [2:0] occupancy;

  logic [1:0] pht [256];
  logic       pre_en;
  logic [7:0] pre_idx;
  logic [1:0] pre_val;
  logic [9:0] wq [$];

  int n_cmp = 0;
  int n_err = 0;

  pht_update_unit #(.entry(8), .depth(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .resolve_valid     (resolve_valid),
    .resolve_index     (resolve_index),
    .resolve_taken     (resolve_taken),
    .resolve_ready     (resolve_ready),
    .pht_write_index   (pht_write_index),
    .pht_current_state (pht_current_state),
    .pht_load          (pht_load),
    .pht_in            (pht_in),
    .occupancy         (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PHT model: combinational state read, falling-edge write.
  assign pht_current_state = pht[pht_write_index];
  always @(negedge clk) begin
    if (pht_load) begin
      pht[pht_write_index] <= pht_in;
      wq.push_back({pht_write_index, pht_in});
    end
    if (pre_en) pht[pre_idx] <= pre_val;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [7:0] idx, input logic [1:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_en  = 1'b1;
    @(negedge clk);
    #1;
    pre_en  = 1'b0;
  endtask

  // One isolated update: push at E1, LOOKUP after E2, COMMIT after E3, IDLE after E4.
  task automatic single(input string tag, input logic [7:0] idx, input logic tk,
                        input logic exp_load, input logic [1:0] exp_in,
                        input logic [1:0] exp_final);
    resolve_valid = 1'b1;
    resolve_index = idx;
    resolve_taken = tk;
    tick();
    resolve_valid = 1'b0;
    chk({tag, "_occ1"}, occupancy, 1);
    chk({tag, "_load_c0"}, pht_load, 0);
    tick();
    chk({tag, "_widx_lk"}, pht_write_index, idx);
    chk({tag, "_load_lk"}, pht_load, 0);
    tick();
    chk({tag, "_load_cm"}, pht_load, exp_load);
    chk({tag, "_in_cm"}, pht_in, exp_in);
    chk({tag, "_widx_cm"}, pht_write_index, idx);
    tick();
    chk({tag, "_load_idle"}, pht_load, 0);
    chk({tag, "_widx_idle"}, pht_write_index, 0);
    chk({tag, "_occ0"}, occupancy, 0);
    chk({tag, "_pht"}, pht[idx], exp_final);
  endtask

  initial begin
    logic rdy_prev;
    int   acc;
    rst_n = 1'b0;
    resolve_valid = 1'b0;
    resolve_index = '0;
    resolve_taken = 1'b0;
    pre_en  = 1'b0;
    pre_idx = '0;
    pre_val = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_occ", occupancy, 0);
    chk("rst_ready", resolve_ready, 1);
    chk("rst_load", pht_load, 0);
    chk("rst_in", pht_in, 0);
    chk("rst_widx", pht_write_index, 0);
    rst_n = 1'b1;
    tick();

    // single update and saturation
    preset(8'h12, 2'b00);
    single("one", 8'h12, 1'b1, 1'b1, 2'b01, 2'b01);
    preset(8'h05, 2'b11);
    single("sat_t", 8'h05, 1'b1, 1'b0, 2'b11, 2'b11);
    preset(8'h06, 2'b00);
    single("sat_n", 8'h06, 1'b0, 1'b0, 2'b00, 2'b00);

    // same-index accumulation
    preset(8'h40, 2'b01);
    resolve_valid = 1'b1; resolve_index = 8'h40; resolve_taken = 1'b1;
    tick();
    resolve_taken = 1'b1;
    tick();
    resolve_taken = 1'b0;
    tick();
    resolve_valid = 1'b0;
    chk("acc_in1", pht_in, 2'b10);
    chk("acc_ld1", pht_load, 1);
    tick();
    chk("acc_lk2", pht_load, 0);
    tick();
    chk("acc_in2", pht_in, 2'b11);
    chk("acc_ld2", pht_load, 1);
    tick();
    tick();
    chk("acc_in3", pht_in, 2'b10);
    chk("acc_ld3", pht_load, 1);
    tick();
    chk("acc_pht", pht[8'h40], 2'b10);
    chk("acc_occ", occupancy, 0);

    // backpressure: valid held for 8 edges, six entries accepted
    for (int i = 0; i < 8; i++) preset(8'h80 + 8'(i), 2'b00);
    tick();
    wq.delete();
    acc = 0;
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    resolve_index = 8'h80;
    rdy_prev = resolve_ready;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (rdy_prev) begin
        acc++;
        resolve_index = 8'h80 + 8'(acc);
      end
      if (c == 5 || c == 7) begin
        chk("bp_occ_full", occupancy, 4);
        chk("bp_ready_full", resolve_ready, 0);
      end
      rdy_prev = resolve_ready;
    end
    resolve_valid = 1'b0;
    repeat (8) tick();
    chk("bp_occ_end", occupancy, 0);
    chk("bp_nwr", wq.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("bp_wr", wq[i], {8'h80 + 8'(i), 2'b01});
    chk("bp_unwritten", pht[8'h86], 2'b00);

    // reset during COMMIT
    preset(8'h33, 2'b10);
    resolve_valid = 1'b1; resolve_index = 8'h33; resolve_taken = 1'b0;
    tick();
    resolve_valid = 1'b0;
    tick();
    tick();
    chk("rc_load_pre", pht_load, 1);
    chk("rc_in_pre", pht_in, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rc_load", pht_load, 0);
    chk("rc_occ", occupancy, 0);
    chk("rc_ready", resolve_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rc_pht", pht[8'h33], 2'b10);
    chk("rc_widx", pht_write_index, 0);
    chk("rc_load_post", pht_load, 0);
    chk("rc_occ_post", occupancy, 0);

    // pointer wrap with pushes landing on COMMIT pops
    for (int i = 0; i < 10; i++) preset(8'h90 + 8'(i), 2'b01);
    tick();
    wq.delete();
    resolve_valid = 1'b1; resolve_index = 8'h90; resolve_taken = 1'b1;
    tick();
    resolve_valid = 1'b0;
    chk("wr_occ0", occupancy, 1);
    tick();
    for (int k = 1; k < 10; k++) begin
      tick();
      resolve_valid = 1'b1;
      resolve_index = 8'h90 + 8'(k);
      resolve_taken = (k % 2 == 0);
      tick();
      resolve_valid = 1'b0;
      chk("wr_occ", occupancy, 1);
      chk("wr_widx", pht_write_index, 8'h90 + 8'(k));
    end
    repeat (3) tick();
    chk("wr_occ_end", occupancy, 0);
    chk("wr_nwr", wq.size(), 10);
    for (int i = 0; i < 10; i++)
      chk("wr_wr", wq[i], {8'h90 + 8'(i), (i % 2 == 0) ? 2'b10 : 2'b00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pht_update_unit.md
# pht_update_unit

Writer-side companion to the 2-bit pattern history table (PHT) in the branch predictor. It accepts resolved branch outcomes from the execute stage and buffers them in a small FIFO. For each entry it reads the current counter through the PHT's write-side state port, computes the saturating-counter update, and drives the PHT's `load`/`in`/`write_index` inputs. Fetch-side lookups (`read_index`/`pht_out`) are untouched by this block.

## Interface
- `entry`, default 8: PHT index width; the PHT has 2**entry counters.
- `depth`, default 4: resolve FIFO depth; power of two, at least 2.

- `clk`  input  1: clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `resolve_valid`  input  1: resolved branch offered this cycle.
- `resolve_index`  input  entry: PHT index of the resolved branch.
- `resolve_taken`  input  1: actual outcome; 1 = taken.
- `resolve_ready`  output  1: FIFO can accept an entry; equals !full.
- `pht_write_index`  output  entry: index presented to the PHT write/state port.
- `pht_current_state`  input  2: PHT counter at `pht_write_index`; combinational from the PHT.
- `pht_load`  output  1: PHT write enable; the PHT writes on the falling clock edge.
- `pht_in`  output  2: new counter value.
- `occupancy`  output  $clog2(depth)+1: number of FIFO entries.

## Operation
- **FIFO**
  - Stores {index, taken}.
  - Push when `resolve_valid && resolve_ready`.
  - Pop only at the end of a COMMIT cycle.
  - `resolve_ready` is derived from the registered count. When full, a push is refused even in a cycle that pops.
  - Push and pop in the same cycle leave the count unchanged.
  - Read and write pointers wrap modulo `depth`.
- **FSM** (states IDLE, LOOKUP, COMMIT):
  - IDLE → LOOKUP when occupancy != 0.
  - LOOKUP → COMMIT unconditionally. On this edge the unit registers `pht_in = sat(pht_current_state, head.taken)`.
    - It also registers `pht_load = (new != pht_current_state)`.
  - COMMIT → LOOKUP if occupancy after the pop is nonzero, counting a same-cycle push. Otherwise COMMIT → IDLE.
  - In both cases the registered `pht_load` clears to 0 on leaving COMMIT.
- **Saturating update**
  - Taken: 00→01→10→11, and 11 stays 11.
  - Not taken: 11→10→01→00, and 00 stays 00.
  - A saturated entry produces no PHT write: COMMIT still occurs and the entry pops, but `pht_load` stays 0.
- **Write index**
  - `pht_write_index` = head index while in LOOKUP or COMMIT, and 0 in IDLE.
  - It is registered so that it is stable for the whole cycle.
- **Same-index hazard**
  - The PHT writes at the falling edge of COMMIT, so the following LOOKUP already sees the new value.
  - Consecutive updates to the same index therefore accumulate correctly with no forwarding.
- **Reset (asynchronous, any state)**
  - State = IDLE, FIFO emptied, occupancy = 0.
  - `pht_load` = 0, `pht_in` = 00, `pht_write_index` = 0.
  - `resolve_ready` = 1.
  - An in-flight COMMIT is abandoned: `pht_load` drops immediately, so no falling-edge write occurs once reset is asserted.

## Timing
- Cycle 0: push accepted at the rising edge into an empty FIFO; occupancy = 1.
- Cycle 1: LOOKUP, with `pht_write_index` = index.
- Cycle 2: COMMIT, with `pht_load`/`pht_in` valid. The PHT is written at the falling edge of cycle 2, and the entry pops at the rising edge ending cycle 2.
- Latency from push to PHT write: 2 cycles plus half a cycle.
- Sustained throughput: one update per 2 cycles.
- The FIFO absorbs bursts up to `depth`.
- `resolve_ready` deasserts the cycle after occupancy reaches `depth`, and reasserts the cycle after a pop from full.

## Test plan
- **Single update:** reset, PHT[0x12]=00, push {0x12, taken} → `pht_load`=1 and `pht_in`=01 in cycle 2 only; PHT[0x12]=01 afterwards; FSM returns to IDLE in cycle 3.
- **Saturation:** PHT[0x05]=11, push taken → COMMIT with `pht_load`=0 and PHT unchanged. Then PHT[0x06]=00, push not-taken → `pht_load`=0.
- **Same-index accumulation:** PHT[0x40]=01, push taken, taken, not-taken on consecutive cycles → successive `pht_in` values 10, 11, 10, one every 2 cycles; final PHT[0x40]=10.
- **Backpressure:** hold `resolve_valid`=1 with distinct indices for 8 cycles (depth=4) → `occupancy` peaks at 4 and `resolve_ready`=0 while full. No entry is lost or duplicated; the PHT writes match the accepted entries in order.
- **Reset mid-COMMIT:** assert `rst_n`=0 during cycle 2 of an update → `pht_load` drops immediately and the PHT entry keeps its old value. `occupancy`=0 and `resolve_ready`=1; after release, the FSM stays in IDLE.
- **Pointer wrap:** run 10 pushes and pops with depth=4, interleaving a push in the same cycle as a COMMIT pop → entries commit in FIFO order across the wrap, and `occupancy` stays consistent.
